// File: rtl/multi_vc_buffer.sv
// multi_vc_buffer: NUM_VC independent circular flit FIFOs of DEPTH entries each,
// sitting between link receive logic and the per-VC input state of a router port.
// One write and one read per cycle, on any VCs. Each VC has its own pointers,
// occupancy count, full/empty flags and an on/off flow-control flag with hysteresis.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   wr_en_i         write request; wr_vc_i selects the VC, data_i is the flit
//   rd_en_i         pop request; rd_vc_i selects the VC
//   head_data_o     head flit of every VC, VC v at [v*DATA_W +: DATA_W] (from storage)
//   is_empty_o      per-VC empty flag (registered)
//   is_full_o       per-VC full flag (registered)
//   on_off_o        per-VC on/off credit flag (registered)
//   count_o         per-VC occupancy, VC v at [v*CNT_W +: CNT_W] (registered)
//   overflow_o      sticky: a write was dropped
//   underflow_o     sticky: a read was ignored
module multi_vc_buffer #(
  parameter int NUM_VC     = 2,
  parameter int DEPTH      = 8,
  parameter int DATA_W     = 64,
  parameter int OFF_THRESH = 2,
  parameter int ON_THRESH  = 2,
  localparam int VC_W      = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
  localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [VC_W-1:0]          wr_vc_i,
  input  logic [DATA_W-1:0]        data_i,
  input  logic                     rd_en_i,
  input  logic [VC_W-1:0]          rd_vc_i,
  output logic [NUM_VC*DATA_W-1:0] head_data_o,
  output logic [NUM_VC-1:0]        is_empty_o,
  output logic [NUM_VC-1:0]        is_full_o,
  output logic [NUM_VC-1:0]        on_off_o,
  output logic [NUM_VC*CNT_W-1:0]  count_o,
  output logic                     overflow_o,
  output logic                     underflow_o
);

  logic [DATA_W-1:0] mem_q [NUM_VC][DEPTH];

  logic [PTR_W-1:0]  wptr_q  [NUM_VC];
  logic [PTR_W-1:0]  wptr_d  [NUM_VC];
  logic [PTR_W-1:0]  rptr_q  [NUM_VC];
  logic [PTR_W-1:0]  rptr_d  [NUM_VC];
  logic [CNT_W-1:0]  count_q [NUM_VC];
  logic [CNT_W-1:0]  count_d [NUM_VC];

  logic [NUM_VC-1:0] empty_q, empty_d;
  logic [NUM_VC-1:0] full_q, full_d;
  logic [NUM_VC-1:0] on_off_q, on_off_d;
  logic [NUM_VC-1:0] wr_hit, rd_hit;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  // Modulo-DEPTH increment; DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return ptr + PTR_W'(1);
  endfunction

  // Acceptance decode. An out-of-range VC index matches no queue, so it
  // falls through to the drop/ignore path without any explicit range check.
  always_comb begin
    rd_hit = '0;
    wr_hit = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      rd_hit[v] = rd_en_i && (rd_vc_i == VC_W'(v)) && (count_q[v] != '0);
      // A full queue still takes a write when the same VC pops this cycle.
      wr_hit[v] = wr_en_i && (wr_vc_i == VC_W'(v)) &&
                  ((count_q[v] != CNT_W'(DEPTH)) || rd_hit[v]);
    end
    overflow_d  = overflow_q  || (wr_en_i && (wr_hit == '0));
    underflow_d = underflow_q || (rd_en_i && (rd_hit == '0));
  end

  // Per-VC next state: pointers, count, flags and on/off hysteresis.
  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      wptr_d[v]   = wr_hit[v] ? ptr_inc(wptr_q[v]) : wptr_q[v];
      rptr_d[v]   = rd_hit[v] ? ptr_inc(rptr_q[v]) : rptr_q[v];
      count_d[v]  = count_q[v] + CNT_W'(wr_hit[v]) - CNT_W'(rd_hit[v]);
      empty_d[v]  = (count_d[v] == '0);
      full_d[v]   = (count_d[v] == CNT_W'(DEPTH));
      on_off_d[v] = on_off_q[v];
      if (wr_hit[v] && !rd_hit[v] && (int'(count_d[v]) > DEPTH - OFF_THRESH)) begin
        on_off_d[v] = 1'b0;
      end else if (rd_hit[v] && !wr_hit[v] && (int'(count_d[v]) < ON_THRESH)) begin
        on_off_d[v] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < NUM_VC; v++) begin
        wptr_q[v]  <= '0;
        rptr_q[v]  <= '0;
        count_q[v] <= '0;
      end
      empty_q     <= '1;
      full_q      <= '0;
      on_off_q    <= '1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        wptr_q[v]  <= wptr_d[v];
        rptr_q[v]  <= rptr_d[v];
        count_q[v] <= count_d[v];
      end
      empty_q     <= empty_d;
      full_q      <= full_d;
      on_off_q    <= on_off_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Flit storage is deliberately not reset; reset only clears the pointers.
  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VC; v++) begin
      if (wr_hit[v] && !rst) begin
        mem_q[v][wptr_q[v]] <= data_i;
      end
    end
  end

  always_comb begin
    head_data_o = '0;
    count_o     = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      head_data_o[v*DATA_W +: DATA_W] = mem_q[v][rptr_q[v]];
      count_o[v*CNT_W +: CNT_W]       = count_q[v];
    end
  end

  assign is_empty_o  = empty_q;
  assign is_full_o   = full_q;
  assign on_off_o    = on_off_q;
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;

endmodule

// File: tb/tb_multi_vc_buffer.sv
// Directed bench for multi_vc_buffer. Instance a: NUM_VC=2, DEPTH=8, DATA_W=64.
// Instance b: NUM_VC=2, DEPTH=5, DATA_W=8, used for wrap-around and full-queue
// read+write cases. Expected values are hand-computed constants.
module tb_multi_vc_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Instance a signals
  logic         a_rst, a_wr_en, a_rd_en;
  logic [0:0]   a_wr_vc, a_rd_vc;
  logic [63:0]  a_data;
  logic [127:0] a_head;
  logic [1:0]   a_empty, a_full, a_on_off;
  logic [7:0]   a_count;
  logic         a_ovf, a_unf;

  // Instance b signals
  logic         b_rst, b_wr_en, b_rd_en;
  logic [0:0]   b_wr_vc, b_rd_vc;
  logic [7:0]   b_data;
  logic [15:0]  b_head;
  logic [1:0]   b_empty, b_full, b_on_off;
  logic [5:0]   b_count;
  logic         b_ovf, b_unf;

  multi_vc_buffer #(.NUM_VC(2), .DEPTH(8), .DATA_W(64)) u_dut_a (
    .clk         (clk),
    .rst         (a_rst),
    .wr_en_i     (a_wr_en),
    .wr_vc_i     (a_wr_vc),
    .data_i      (a_data),
    .rd_en_i     (a_rd_en),
    .rd_vc_i     (a_rd_vc),
    .head_data_o (a_head),
    .is_empty_o  (a_empty),
    .is_full_o   (a_full),
    .on_off_o    (a_on_off),
    .count_o     (a_count),
    .overflow_o  (a_ovf),
    .underflow_o (a_unf)
  );

  multi_vc_buffer #(.NUM_VC(2), .DEPTH(5), .DATA_W(8)) u_dut_b (
    .clk         (clk),
    .rst         (b_rst),
    .wr_en_i     (b_wr_en),
    .wr_vc_i     (b_wr_vc),
    .data_i      (b_data),
    .rd_en_i     (b_rd_en),
    .rd_vc_i     (b_rd_vc),
    .head_data_o (b_head),
    .is_empty_o  (b_empty),
    .is_full_o   (b_full),
    .on_off_o    (b_on_off),
    .count_o     (b_count),
    .overflow_o  (b_ovf),
    .underflow_o (b_unf)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then return to idle inputs 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
    a_rst = 1'b0; a_wr_en = 1'b0; a_rd_en = 1'b0;
    b_rst = 1'b0; b_wr_en = 1'b0; b_rd_en = 1'b0;
  endtask

  task automatic a_op(input logic wr, input logic [0:0] wvc, input logic [63:0] d,
                      input logic rd, input logic [0:0] rvc);
    a_wr_en = wr; a_wr_vc = wvc; a_data = d; a_rd_en = rd; a_rd_vc = rvc;
    step();
  endtask

  task automatic b_op(input logic wr, input logic [0:0] wvc, input logic [7:0] d,
                      input logic rd, input logic [0:0] rvc);
    b_wr_en = wr; b_wr_vc = wvc; b_data = d; b_rd_en = rd; b_rd_vc = rvc;
    step();
  endtask

  initial begin
    a_wr_en = 0; a_rd_en = 0; a_wr_vc = 0; a_rd_vc = 0; a_data = '0;
    b_wr_en = 0; b_rd_en = 0; b_wr_vc = 0; b_rd_vc = 0; b_data = '0;
    a_rst = 1'b1; b_rst = 1'b1;
    @(posedge clk);
    #1;
    a_rst = 1'b1; b_rst = 1'b1;
    step();
    step();

    // Reset state
    check("a_rst_empty",  64'(a_empty),  64'h3);
    check("a_rst_full",   64'(a_full),   64'h0);
    check("a_rst_on_off", 64'(a_on_off), 64'h3);
    check("a_rst_count",  64'(a_count),  64'h0);
    check("a_rst_ovf",    64'(a_ovf),    64'h0);
    check("a_rst_unf",    64'(a_unf),    64'h0);
    check("b_rst_empty",  64'(b_empty),  64'h3);

    // Fill VC1 with 0x10..0x17
    for (int i = 0; i < 8; i++) begin
      a_op(1'b1, 1'b1, 64'(8'h10 + i), 1'b0, 1'b0);
      check($sformatf("a_fill_cnt%0d", i), 64'(a_count[7:4]), 64'(i + 1));
      check($sformatf("a_fill_onoff%0d", i), 64'(a_on_off[1]), (i + 1 > 6) ? 64'h0 : 64'h1);
      check($sformatf("a_fill_full%0d", i), 64'(a_full[1]), (i == 7) ? 64'h1 : 64'h0);
    end
    check("a_fill_head",   a_head[127:64], 64'h10);
    check("a_vc0_empty",   64'(a_empty[0]), 64'h1);
    check("a_vc0_cnt",     64'(a_count[3:0]), 64'h0);
    check("a_no_ovf_yet",  64'(a_ovf), 64'h0);

    // 9th write is dropped
    a_op(1'b1, 1'b1, 64'h99, 1'b0, 1'b0);
    check("a_ovf_set",     64'(a_ovf), 64'h1);
    check("a_ovf_cnt",     64'(a_count[7:4]), 64'h8);

    // Drain VC1
    for (int i = 0; i < 8; i++) begin
      check($sformatf("a_pop_head%0d", i), a_head[127:64], 64'(8'h10 + i));
      a_op(1'b0, 1'b0, 64'h0, 1'b1, 1'b1);
      check($sformatf("a_pop_cnt%0d", i), 64'(a_count[7:4]), 64'(7 - i));
      check($sformatf("a_pop_onoff%0d", i), 64'(a_on_off[1]), (7 - i <= 1) ? 64'h1 : 64'h0);
    end
    check("a_drain_empty", 64'(a_empty[1]), 64'h1);
    check("a_drain_unf",   64'(a_unf), 64'h0);

    // Empty VC1: write+read same cycle, no bypass
    a_op(1'b1, 1'b1, 64'h55, 1'b1, 1'b1);
    check("a_bypass_unf",  64'(a_unf), 64'h1);
    check("a_bypass_cnt",  64'(a_count[7:4]), 64'h1);
    check("a_bypass_head", a_head[127:64], 64'h55);
    check("a_bypass_emp",  64'(a_empty), 64'h1);

    // Different-VC write and read in the same cycle
    a_op(1'b1, 1'b0, 64'h77, 1'b1, 1'b1);
    check("a_xvc_cnt",     64'(a_count), 64'h01);
    check("a_xvc_head0",   a_head[63:0], 64'h77);

    // Reset while traffic is being driven
    a_rst = 1'b1;
    a_op(1'b1, 1'b0, 64'h88, 1'b0, 1'b0);
    check("a_mrst_empty",  64'(a_empty),  64'h3);
    check("a_mrst_count",  64'(a_count),  64'h0);
    check("a_mrst_on_off", 64'(a_on_off), 64'h3);
    check("a_mrst_flags",  64'({a_ovf, a_unf}), 64'h0);

    // DEPTH=5 wrap: 13 write/pop pairs on VC0
    for (int i = 0; i < 13; i++) begin
      b_op(1'b1, 1'b0, 8'(8'h30 + i), 1'b0, 1'b0);
      check($sformatf("b_wrap_head%0d", i), 64'(b_head[7:0]), 64'(8'h30 + i));
      check($sformatf("b_wrap_cnt%0d", i), 64'(b_count[2:0]), 64'h1);
      b_op(1'b0, 1'b0, 8'h0, 1'b1, 1'b0);
      check($sformatf("b_wrap_emp%0d", i), 64'(b_empty[0]), 64'h1);
    end

    // Fill VC0 (write pointer now at 3, so the fill wraps too)
    for (int i = 0; i < 5; i++) begin
      b_op(1'b1, 1'b0, 8'(8'hA0 + i), 1'b0, 1'b0);
    end
    check("b_fill_full",   64'(b_full[0]), 64'h1);
    check("b_fill_onoff",  64'(b_on_off[0]), 64'h0);

    // Full queue: write 0xAA and pop in the same cycle
    b_op(1'b1, 1'b0, 8'hAA, 1'b1, 1'b0);
    check("b_fullrw_cnt",  64'(b_count[2:0]), 64'h5);
    check("b_fullrw_full", 64'(b_full[0]), 64'h1);
    check("b_fullrw_ovf",  64'(b_ovf), 64'h0);
    check("b_fullrw_onof", 64'(b_on_off[0]), 64'h0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("b_tail_head%0d", i), 64'(b_head[7:0]),
            (i == 4) ? 64'hAA : 64'(8'hA1 + i));
      b_op(1'b0, 1'b0, 8'h0, 1'b1, 1'b0);
    end
    check("b_tail_empty",  64'(b_empty[0]), 64'h1);
    check("b_tail_onoff",  64'(b_on_off[0]), 64'h1);
    check("b_tail_unf",    64'(b_unf), 64'h0);

    // Read of an empty queue is ignored
    b_op(1'b0, 1'b0, 8'h0, 1'b1, 1'b1);
    check("b_empty_unf",   64'(b_unf), 64'h1);
    check("b_empty_cnt",   64'(b_count), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
